sram_like_arbiter: RTL and testbench

//  Parametrised N-channel arbiter merging sram-like master ports onto one sram-like slave port.

---
 rtl/sram_like_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_like_arbiter.sv | 512 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// N-channel arbiter merging sram-like master ports onto one sram-like slave port.
// The request path is combinational. An id FIFO records which channel issued each
// accepted request, so every in-order slave response is steered back to its issuer.
module sram_like_arbiter #(
    parameter int NCH         = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int OUTSTANDING = 4,
    parameter int MODE        = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        m_req,
    input  logic [NCH-1:0]        m_wr,
    input  logic [2*NCH-1:0]      m_size,
    input  logic [DW/8*NCH-1:0]   m_wstrb,
    input  logic [AW*NCH-1:0]     m_addr,
    input  logic [DW*NCH-1:0]     m_wdata,
    output logic [NCH-1:0]        m_addr_ok,
    output logic [NCH-1:0]        m_data_ok,
    output logic [DW-1:0]         m_rdata,
    output logic                  s_req,
    output logic                  s_wr,
    output logic [1:0]            s_size,
    output logic [DW/8-1:0]       s_wstrb,
    output logic [AW-1:0]         s_addr,
    output logic [DW-1:0]         s_wdata,
    input  logic                  s_addr_ok,
    input  logic                  s_data_ok,
    input  logic [DW-1:0]         s_rdata,
    output logic                  err
);

    localparam int SW  = DW / 8;
    localparam int IDW = $clog2(NCH);
    localparam int PW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW  = $clog2(OUTSTANDING + 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(OUTSTANDING - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(OUTSTANDING);

    logic [IDW-1:0] id_fifo [OUTSTANDING];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [IDW-1:0] rr_ptr;
    logic           lock_valid;
    logic [IDW-1:0] lock_id;
    logic [IDW-1:0] arb_id;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] grant;
    logic           full;
    logic           push;
    logic           pop;

    // Pick a requester: lowest index (fixed priority) or first at/after rr_ptr (round-robin).
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        arb_id = '0;
        cand   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (MODE == 0) begin
                cand = IDW'(k);
            end else begin
                cand = IDW'((int'(rr_ptr) + k) % NCH);
            end
            if (m_req[cand]) begin
                arb_id = cand;
            end
        end
    end

    // A stalled request keeps its registered grant until the slave accepts it.
    assign grant = lock_valid ? lock_id : arb_id;

    assign full      = (count == COUNT_MAX);
    assign s_req     = (|m_req) & ~full & ~rst;
    assign push      = s_req & s_addr_ok;
    assign pop       = s_data_ok & (count != '0) & ~rst;
    assign m_addr_ok = push ? (NCH'(1) << grant) : '0;
    assign m_data_ok = pop ? (NCH'(1) << id_fifo[rd_ptr]) : '0;
    assign m_rdata   = rst ? '0 : s_rdata;

    // Steer the granted channel's command fields onto the slave port.
    always_comb begin
        s_wr    = 1'b0;
        s_size  = '0;
        s_wstrb = '0;
        s_addr  = '0;
        s_wdata = '0;
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                if (grant == IDW'(i)) begin
                    s_wr    = m_wr[i];
                    s_size  = m_size[2*i +: 2];
                    s_wstrb = m_wstrb[SW*i +: SW];
                    s_addr  = m_addr[AW*i +: AW];
                    s_wdata = m_wdata[DW*i +: DW];
                end
            end
        end
    end

    // Track FIFO pointers and occupancy, the grant lock, round-robin pointer and sticky error.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_id    <= '0;
            err        <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr     <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
                lock_valid <= 1'b0;
                if (MODE != 0) begin
                    rr_ptr <= IDW'((int'(grant) + 1) % NCH);
                end
            end else if (s_req) begin
                lock_valid <= 1'b1;
                lock_id    <= grant;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (s_data_ok && (count == '0)) begin
                err <= 1'b1;
            end
        end
    end

    // Record the issuing channel of each accepted request.
    // NOTE: the id storage has no reset; entries are only read once the pointers mark them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            id_fifo[wr_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Testbench for sram_like_arbiter: a fixed-priority instance (depth 4) and a
// round-robin instance (depth 2) checked against a queue-based reference model.
module tb_sram_like_arbiter;

    localparam int NCH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [2];
    logic [1:0]  m_req     [2];
    logic [1:0]  m_wr      [2];
    logic [3:0]  m_size    [2];
    logic [7:0]  m_wstrb   [2];
    logic [63:0] m_addr    [2];
    logic [63:0] m_wdata   [2];
    logic [1:0]  m_addr_ok [2];
    logic [1:0]  m_data_ok [2];
    logic [31:0] m_rdata   [2];
    logic        s_req     [2];
    logic        s_wr      [2];
    logic [1:0]  s_size    [2];
    logic [3:0]  s_wstrb   [2];
    logic [31:0] s_addr    [2];
    logic [31:0] s_wdata   [2];
    logic        s_addr_ok [2];
    logic        s_data_ok [2];
    logic [31:0] s_rdata   [2];
    logic        err       [2];

    int errors = 0;
    int checks = 0;

    sram_like_arbiter #(.NCH(2), .AW(32), .DW(32), .OUTSTANDING(4), .MODE(0)) u_fixed (
        .clk(clk), .rst(rst[0]), .m_req(m_req[0]), .m_wr(m_wr[0]), .m_size(m_size[0]),
        .m_wstrb(m_wstrb[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
        .m_addr_ok(m_addr_ok[0]), .m_data_ok(m_data_ok[0]), .m_rdata(m_rdata[0]),
        .s_req(s_req[0]), .s_wr(s_wr[0]), .s_size(s_size[0]), .s_wstrb(s_wstrb[0]),
        .s_addr(s_addr[0]), .s_wdata(s_wdata[0]), .s_addr_ok(s_addr_ok[0]),
        .s_data_ok(s_data_ok[0]), .s_rdata(s_rdata[0]), .err(err[0])
    );

    sram_like_arbiter #(.NCH(2), .AW(32), .DW(32), .OUTSTANDING(2), .MODE(1)) u_rr (
        .clk(clk), .rst(rst[1]), .m_req(m_req[1]), .m_wr(m_wr[1]), .m_size(m_size[1]),
        .m_wstrb(m_wstrb[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
        .m_addr_ok(m_addr_ok[1]), .m_data_ok(m_data_ok[1]), .m_rdata(m_rdata[1]),
        .s_req(s_req[1]), .s_wr(s_wr[1]), .s_size(s_size[1]), .s_wstrb(s_wstrb[1]),
        .s_addr(s_addr[1]), .s_wdata(s_wdata[1]), .s_addr_ok(s_addr_ok[1]),
        .s_data_ok(s_data_ok[1]), .s_rdata(s_rdata[1]), .err(err[1])
    );

    // ---------------- reference model ----------------
    int mode_m  [2] = '{0, 1};
    int depth_m [2] = '{4, 2};
    int q0 [$];
    int q1 [$];
    int rr_m    [2] = '{0, 0};
    bit lock_v  [2] = '{0, 0};
    int lock_id [2] = '{0, 0};
    bit err_m   [2] = '{0, 0};

    bit         e_sreq    [2];
    int         e_grant   [2];
    logic [1:0] e_addr_ok [2];
    logic [1:0] e_data_ok [2];
    bit         e_pop     [2];

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int qhead(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    function automatic logic [1:0] onehot(input int i);
        logic [1:0] v;
        v = 2'b00;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_eval(input int d);
        bit found;
        int c;
        found = 0;
        e_grant[d] = 0;
        if (lock_v[d]) begin
            e_grant[d] = lock_id[d];
        end else begin
            for (int k = 0; k < NCH; k++) begin
                c = (mode_m[d] == 0) ? k : (rr_m[d] + k) % NCH;
                if (!found && m_req[d][c]) begin
                    e_grant[d] = c;
                    found = 1;
                end
            end
        end
        e_sreq[d]    = (rst[d] === 1'b0) && (m_req[d] != 2'b00) && (qsize(d) < depth_m[d]);
        e_addr_ok[d] = (e_sreq[d] && s_addr_ok[d]) ? onehot(e_grant[d]) : 2'b00;
        e_pop[d]     = (rst[d] === 1'b0) && s_data_ok[d] && (qsize(d) > 0);
        e_data_ok[d] = e_pop[d] ? onehot(qhead(d)) : 2'b00;
    endtask

    task automatic model_commit(input int d);
        model_eval(d);
        if (rst[d]) begin
            if (d == 0) q0.delete(); else q1.delete();
            rr_m[d] = 0; lock_v[d] = 0; lock_id[d] = 0; err_m[d] = 0;
        end else begin
            if (s_data_ok[d] && qsize(d) == 0) err_m[d] = 1;
            if (e_pop[d]) begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (e_addr_ok[d] != 2'b00) begin
                if (d == 0) q0.push_back(e_grant[d]); else q1.push_back(e_grant[d]);
                lock_v[d] = 0;
                if (mode_m[d] == 1) rr_m[d] = (e_grant[d] + 1) % NCH;
            end else if (e_sreq[d]) begin
                lock_v[d] = 1;
                lock_id[d] = e_grant[d];
            end
        end
    endtask

    // Inputs change #1 after posedge; outputs are sampled at the negedge.
    task automatic mid();
        @(negedge clk);
        model_eval(0);
        model_eval(1);
    endtask

    task automatic tick();
        model_commit(0);
        model_commit(1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs(input int d);
        m_req[d] = '0; m_wr[d] = '0; m_size[d] = '0; m_wstrb[d] = '0;
        m_addr[d] = '0; m_wdata[d] = '0;
        s_addr_ok[d] = 1'b0; s_data_ok[d] = 1'b0; s_rdata[d] = '0;
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        s_data_ok[d] = 1'b1;
        while (qsize(d) > 0 && n < 10) begin
            s_rdata[d] = $urandom();
            mid();
            checks++;
            if (m_data_ok[d] !== e_data_ok[d]) begin
                errors++;
                $display("FAIL drain%0d_data_ok got=%b exp=%b", d, m_data_ok[d], e_data_ok[d]);
            end
            tick();
            n++;
        end
        s_data_ok[d] = 1'b0;
        checks++;
        if (qsize(d) != 0) begin
            errors++;
            $display("FAIL drain%0d_timeout got=%0d pending exp=0", d, qsize(d));
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; m_req[d] = 2'b11; s_addr_ok[d] = 1'b1;
            s_data_ok[d] = 1'b1; s_rdata[d] = 32'h5a5a5a5a;
        end
        repeat (2) begin
            mid();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({s_req[d], m_addr_ok[d], m_data_ok[d], err[d]} !== 6'b0) begin
                    errors++;
                    $display("FAIL reset%0d got s_req=%b addr_ok=%b data_ok=%b err=%b exp all 0",
                             d, s_req[d], m_addr_ok[d], m_data_ok[d], err[d]);
                end
                checks++;
                if (m_rdata[d] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset%0d_rdata got=%h exp=0", d, m_rdata[d]);
                end
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            clear_inputs(d);
            rst[d] = 1'b0;
        end
    endtask

    task automatic test_single_read();
        m_req[0] = 2'b01; m_addr[0][31:0] = 32'h1c000000; s_addr_ok[0] = 1'b1;
        mid();
        checks++;
        if (m_addr_ok[0] !== 2'b01 || s_req[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_accept got addr_ok=%b s_req=%b exp 01/1", m_addr_ok[0], s_req[0]);
        end
        checks++;
        if (s_addr[0] !== 32'h1c000000 || s_wr[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_addr got=%h wr=%b exp=1c000000 wr=0", s_addr[0], s_wr[0]);
        end
        tick();
        m_req[0] = 2'b00; s_addr_ok[0] = 1'b0;
        repeat (2) begin
            mid();
            checks++;
            if (m_data_ok[0] !== 2'b00) begin
                errors++;
                $display("FAIL single_idle got=%b exp=00", m_data_ok[0]);
            end
            tick();
        end
        s_data_ok[0] = 1'b1; s_rdata[0] = 32'hdeadbeef;
        mid();
        checks++;
        if (m_data_ok[0] !== 2'b01 || m_rdata[0] !== 32'hdeadbeef) begin
            errors++;
            $display("FAIL single_resp got data_ok=%b rdata=%h exp 01/deadbeef", m_data_ok[0], m_rdata[0]);
        end
        tick();
        s_data_ok[0] = 1'b0;
        mid();
        checks++;
        if (err[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_err got=%b exp=0", err[0]);
        end
        tick();
    endtask

    task automatic test_fixed_priority();
        m_req[0] = 2'b11; m_addr[0] = {32'h200, 32'h100}; s_addr_ok[0] = 1'b1;
        mid();
        checks++;
        if (m_addr_ok[0] !== 2'b01 || s_addr[0] !== 32'h100) begin
            errors++;
            $display("FAIL prio_first got addr_ok=%b addr=%h exp 01/100", m_addr_ok[0], s_addr[0]);
        end
        tick();
        m_req[0] = 2'b10;
        mid();
        checks++;
        if (m_addr_ok[0] !== 2'b10 || s_addr[0] !== 32'h200) begin
            errors++;
            $display("FAIL prio_second got addr_ok=%b addr=%h exp 10/200", m_addr_ok[0], s_addr[0]);
        end
        tick();
        m_req[0] = 2'b00; s_addr_ok[0] = 1'b0; s_data_ok[0] = 1'b1; s_rdata[0] = 32'h11111111;
        mid();
        checks++;
        if (m_data_ok[0] !== 2'b01) begin
            errors++;
            $display("FAIL prio_resp0 got=%b exp=01", m_data_ok[0]);
        end
        tick();
        s_rdata[0] = 32'h22222222;
        mid();
        checks++;
        if (m_data_ok[0] !== 2'b10 || m_rdata[0] !== 32'h22222222) begin
            errors++;
            $display("FAIL prio_resp1 got data_ok=%b rdata=%h exp 10/22222222", m_data_ok[0], m_rdata[0]);
        end
        tick();
        s_data_ok[0] = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ok;
        logic [1:0] prev_ok;
        prev_ok = 2'b00;
        m_req[1] = 2'b11; m_addr[1] = {32'h2000, 32'h1000}; s_addr_ok[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s_data_ok[1] = (qsize(1) > 0);
            s_rdata[1] = $urandom();
            exp_ok = (k % 2 == 0) ? 2'b01 : 2'b10;
            mid();
            checks++;
            if (m_addr_ok[1] !== exp_ok) begin
                errors++;
                $display("FAIL rr_grant%0d got=%b exp=%b", k, m_addr_ok[1], exp_ok);
            end
            if (k > 0) begin
                checks++;
                if (m_data_ok[1] !== prev_ok) begin
                    errors++;
                    $display("FAIL rr_resp%0d got=%b exp=%b", k, m_data_ok[1], prev_ok);
                end
            end
            prev_ok = exp_ok;
            tick();
        end
        m_req[1] = 2'b00; s_addr_ok[1] = 1'b0;
        drain(1);
    endtask

    task automatic test_backpressure();
        logic [1:0] req_seq [6] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
        logic       dok_seq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       sreq_exp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0] aok_exp [6] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
        logic [1:0] dok_exp [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        s_addr_ok[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            m_req[1] = req_seq[k];
            m_addr[1] = (k < 2) ? {32'h400, 32'h300} : {32'h400, 32'h500};
            s_data_ok[1] = dok_seq[k];
            mid();
            checks++;
            if (s_req[1] !== sreq_exp[k] || m_addr_ok[1] !== aok_exp[k] || m_data_ok[1] !== dok_exp[k]) begin
                errors++;
                $display("FAIL bp_cycle%0d got s_req=%b addr_ok=%b data_ok=%b exp %b/%b/%b", k,
                         s_req[1], m_addr_ok[1], m_data_ok[1], sreq_exp[k], aok_exp[k], dok_exp[k]);
            end
            tick();
        end
        m_req[1] = 2'b00; s_addr_ok[1] = 1'b0; s_data_ok[1] = 1'b1;
        mid();
        checks++;
        if (m_data_ok[1] !== 2'b10) begin
            errors++;
            $display("FAIL bp_resp1 got=%b exp=10", m_data_ok[1]);
        end
        tick();
        mid();
        checks++;
        if (m_data_ok[1] !== 2'b01) begin
            errors++;
            $display("FAIL bp_resp2 got=%b exp=01", m_data_ok[1]);
        end
        tick();
        s_data_ok[1] = 1'b0;
    endtask

    task automatic test_lock();
        m_req[0] = 2'b10; m_wr[0] = 2'b10; m_size[0] = 4'b1000; m_wstrb[0] = 8'hf0;
        m_addr[0] = {32'h600, 32'h700}; m_wdata[0] = {32'hcafef00d, 32'h0};
        s_addr_ok[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) m_req[0] = 2'b11;
            if (k == 2) s_addr_ok[0] = 1'b1;
            if (k == 3) m_req[0] = 2'b01;
            mid();
            if (k < 3) begin
                checks++;
                if (s_addr[0] !== 32'h600 || s_wr[0] !== 1'b1 || s_wdata[0] !== 32'hcafef00d ||
                    s_wstrb[0] !== 4'hf || s_size[0] !== 2'd2) begin
                    errors++;
                    $display("FAIL lock_fields%0d got addr=%h wr=%b wdata=%h wstrb=%h size=%0d exp 600/1/cafef00d/f/2",
                             k, s_addr[0], s_wr[0], s_wdata[0], s_wstrb[0], s_size[0]);
                end
            end
            checks++;
            if (m_addr_ok[0] !== ((k < 2) ? 2'b00 : (k == 2) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL lock_addr_ok%0d got=%b exp=%b", k, m_addr_ok[0],
                         (k < 2) ? 2'b00 : (k == 2) ? 2'b10 : 2'b01);
            end
            tick();
        end
        clear_inputs(0);
        drain(0);
    endtask

    task automatic test_reset_midflight();
        m_req[0] = 2'b11; s_addr_ok[0] = 1'b1;
        tick();
        m_req[0] = 2'b10;
        tick();
        m_req[0] = 2'b01; s_addr_ok[0] = 1'b0; s_data_ok[0] = 1'b1; rst[0] = 1'b1;
        mid();
        checks++;
        if (s_req[0] !== 1'b0 || m_data_ok[0] !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_gate got s_req=%b data_ok=%b exp 0/00", s_req[0], m_data_ok[0]);
        end
        tick();
        rst[0] = 1'b0; m_req[0] = 2'b00;
        mid();
        checks++;
        if (m_data_ok[0] !== 2'b00 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_late got data_ok=%b err=%b exp 00/0", m_data_ok[0], err[0]);
        end
        tick();
        s_data_ok[0] = 1'b0;
        mid();
        checks++;
        if (err[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_err got=%b exp=1", err[0]);
        end
        tick();
        m_req[0] = 2'b11; s_addr_ok[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mid();
            checks++;
            if (s_req[0] !== ((k < 4) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL rstmid_fill%0d got s_req=%b exp=%b", k, s_req[0], (k < 4) ? 1'b1 : 1'b0);
            end
            tick();
        end
        clear_inputs(0);
        drain(0);
        mid();
        checks++;
        if (err[0] !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got=%b exp=1", err[0]);
        end
        tick();
    endtask

    task automatic test_random();
        bit         pend [2][2];
        logic [1:0] acc  [2];
        logic [31:0] ea;
        for (int d = 0; d < 2; d++) begin
            clear_inputs(d);
            rst[d] = 1'b1;
            pend[d][0] = 0;
            pend[d][1] = 0;
        end
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (!pend[d][ch] && $urandom_range(0, 2) == 0) begin
                        pend[d][ch] = 1;
                        m_wr[d][ch] = $urandom_range(0, 1);
                        m_size[d][2*ch +: 2] = 2'($urandom_range(0, 2));
                        m_wstrb[d][4*ch +: 4] = 4'($urandom());
                        m_addr[d][32*ch +: 32] = $urandom();
                        m_wdata[d][32*ch +: 32] = $urandom();
                    end
                    m_req[d][ch] = pend[d][ch];
                end
                s_addr_ok[d] = ($urandom_range(0, 3) != 0);
                s_data_ok[d] = (qsize(d) > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 63) == 0);
                s_rdata[d] = $urandom();
            end
            mid();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (s_req[d] !== e_sreq[d] || m_addr_ok[d] !== e_addr_ok[d] || m_data_ok[d] !== e_data_ok[d]) begin
                    errors++;
                    $display("FAIL rand%0d_c%0d got s_req=%b addr_ok=%b data_ok=%b exp %b/%b/%b", d, cyc,
                             s_req[d], m_addr_ok[d], m_data_ok[d], e_sreq[d], e_addr_ok[d], e_data_ok[d]);
                end
                checks++;
                if (err[d] !== err_m[d]) begin
                    errors++;
                    $display("FAIL rand%0d_err_c%0d got=%b exp=%b", d, cyc, err[d], err_m[d]);
                end
                if (e_pop[d]) begin
                    checks++;
                    if (m_rdata[d] !== s_rdata[d]) begin
                        errors++;
                        $display("FAIL rand%0d_rdata_c%0d got=%h exp=%h", d, cyc, m_rdata[d], s_rdata[d]);
                    end
                end
                if (e_sreq[d]) begin
                    ea = m_addr[d][32*e_grant[d] +: 32];
                    checks++;
                    if (s_addr[d] !== ea || s_wdata[d] !== m_wdata[d][32*e_grant[d] +: 32] ||
                        s_wr[d] !== m_wr[d][e_grant[d]] || s_size[d] !== m_size[d][2*e_grant[d] +: 2] ||
                        s_wstrb[d] !== m_wstrb[d][4*e_grant[d] +: 4]) begin
                        errors++;
                        $display("FAIL rand%0d_fields_c%0d got addr=%h exp=%h (grant ch%0d)",
                                 d, cyc, s_addr[d], ea, e_grant[d]);
                    end
                end
                acc[d] = e_addr_ok[d];
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (acc[d][ch]) pend[d][ch] = 0;
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            clear_inputs(d);
            rst[d] = 1'b1;
        end
        test_reset();
        test_single_read();
        test_fixed_priority();
        test_round_robin();
        test_backpressure();
        test_lock();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
